// File: rtl/ubutterfly_seq_ctrl.sv
// Stage sequencer for one time-shared unary butterfly: per index it loads twiddles,
// clears/loads/runs the butterfly for one bitstream period, counts ones, and hands off results.
module ubutterfly_seq_ctrl #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NUM_BFLY = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iAbort,
  output logic                oBusy,
  output logic [IDX_W-1:0]    oTwAddr,
  input  logic [BITWIDTH-1:0] iTwReal,
  input  logic [BITWIDTH-1:0] iTwImg,
  output logic [BITWIDTH-1:0] owReal,
  output logic [BITWIDTH-1:0] owImg,
  output logic                oClr,
  output logic                oLoadW,
  output logic                oEn,
  input  logic                iReal0,
  input  logic                iImg0,
  input  logic                iReal1,
  input  logic                iImg1,
  output logic [BITWIDTH:0]   oCntReal0,
  output logic [BITWIDTH:0]   oCntImg0,
  output logic [BITWIDTH:0]   oCntReal1,
  output logic [BITWIDTH:0]   oCntImg1,
  output logic [IDX_W-1:0]    oBflyIdx,
  output logic                oValid,
  input  logic                iReady,
  output logic                oStageDone
);

  localparam int unsigned RUN_LAST_I = (1 << BITWIDTH) + PIPE_LAT - 1;
  localparam int unsigned LAST_IDX_I = NUM_BFLY - 1;
  localparam logic [BITWIDTH:0]  RUN_LAST = RUN_LAST_I[BITWIDTH:0];
  localparam logic [BITWIDTH:0]  PL_C     = PIPE_LAT[BITWIDTH:0];
  localparam logic [IDX_W-1:0]   LAST_IDX = LAST_IDX_I[IDX_W-1:0];

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx;
  logic [BITWIDTH:0] cyc;
  logic              hs_next, hs_last, abort_act;

  always_comb begin
    state_n   = state;
    abort_act = (state != S_IDLE) && iAbort;
    hs_next   = 1'b0;
    hs_last   = 1'b0;
    oClr      = 1'b0;
    oLoadW    = 1'b0;
    oEn       = 1'b0;
    oValid    = 1'b0;
    oBusy     = (state != S_IDLE);
    case (state)
      S_IDLE: if (iStart) state_n = S_CLR;
      S_CLR: begin
        oClr    = 1'b1;
        state_n = S_LOAD;
      end
      S_LOAD: begin
        oLoadW  = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: begin
        oEn = 1'b1;
        if (cyc == RUN_LAST) state_n = S_DONE;
      end
      S_DONE: begin
        oValid = 1'b1;
        if (iReady) begin
          if (idx == LAST_IDX) begin
            state_n = S_IDLE;
            hs_last = !iAbort;
          end else begin
            state_n = S_CLR;
            hs_next = !iAbort;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Abort overrides everything, including a handshake in the same cycle
    if (abort_act) state_n = S_IDLE;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state      <= S_IDLE;
      idx        <= '0;
      cyc        <= '0;
      owReal     <= '0;
      owImg      <= '0;
      oCntReal0  <= '0;
      oCntImg0   <= '0;
      oCntReal1  <= '0;
      oCntImg1   <= '0;
      oStageDone <= 1'b0;
    end else begin
      state      <= state_n;
      oStageDone <= hs_last;
      if (state == S_IDLE && iStart) idx <= '0;
      if (hs_next) idx <= idx + 1'b1;
      if (state == S_CLR) begin
        owReal    <= iTwReal;
        owImg     <= iTwImg;
        cyc       <= '0;
        oCntReal0 <= '0;
        oCntImg0  <= '0;
        oCntReal1 <= '0;
        oCntImg1  <= '0;
      end
      // Samples before PIPE_LAT are pipeline fill and are not counted
      if (state == S_RUN && !iAbort) begin
        cyc <= cyc + 1'b1;
        if (cyc >= PL_C) begin
          oCntReal0 <= oCntReal0 + {{BITWIDTH{1'b0}}, iReal0};
          oCntImg0  <= oCntImg0  + {{BITWIDTH{1'b0}}, iImg0};
          oCntReal1 <= oCntReal1 + {{BITWIDTH{1'b0}}, iReal1};
          oCntImg1  <= oCntImg1  + {{BITWIDTH{1'b0}}, iImg1};
        end
      end
    end
  end

  assign oTwAddr  = idx;
  assign oBflyIdx = idx;

endmodule

// File: tb/tb_ubutterfly_seq_ctrl.sv
// Self-checking bench for ubutterfly_seq_ctrl: timeline model of each butterfly plus directed scenarios.
module tb_ubutterfly_seq_ctrl;
  localparam int BW = 4;
  localparam int NB = 4;
  localparam int IW = 2;
  localparam int PL = 2;
  localparam int VT = 2 + (1 << BW) + PL;  // cycles from CLR entry to valid

  logic clk = 1'b0;
  logic rstn, start, abort, ready;
  logic busy, clr, loadw, en, valid, sdone;
  logic [IW-1:0] twaddr, bidx;
  logic [BW-1:0] twre, twim, wre, wim;
  logic r0, i0, r1, i1;
  logic [BW:0] c_r0, c_i0, c_r1, c_i1;

  int checks = 0, failures = 0, ndone = 0;
  bit armed = 0;

  int tbl_re [NB] = '{3, 7, 11, 15};
  int tbl_im [NB] = '{12, 8, 4, 0};

  always #5 clk = ~clk;

  assign twre = tbl_re[twaddr][BW-1:0];
  assign twim = tbl_im[twaddr][BW-1:0];

  ubutterfly_seq_ctrl #(.BITWIDTH(BW), .NUM_BFLY(NB), .IDX_W(IW), .PIPE_LAT(PL)) dut (
    .iClk(clk), .iRstN(rstn), .iStart(start), .iAbort(abort), .oBusy(busy),
    .oTwAddr(twaddr), .iTwReal(twre), .iTwImg(twim), .owReal(wre), .owImg(wim),
    .oClr(clr), .oLoadW(loadw), .oEn(en),
    .iReal0(r0), .iImg0(i0), .iReal1(r1), .iImg1(i1),
    .oCntReal0(c_r0), .oCntImg0(c_i0), .oCntReal1(c_r1), .oCntImg1(c_i1),
    .oBflyIdx(bidx), .oValid(valid), .iReady(ready), .oStageDone(sdone)
  );

  // Stream s at RUN cycle r; fill cycles carry junk ones on iImg0
  function automatic logic sbit(input int s, input int r);
    case (s)
      0:       return 1'b1;
      1:       return r < PL;
      2:       return (r % 2) == 0;
      default: return r == PL + 5;
    endcase
  endfunction

  function automatic int ssum(input int s);
    int acc = 0;
    for (int r = PL; r < PL + (1 << BW); r++) acc += int'(sbit(s, r));
    return acc;
  endfunction

  // Model: m_t = cycles since entering CLR for the current butterfly
  bit m_act = 0, m_done = 0, m_zero = 0;
  int m_t = 0, m_idx = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_act = 0; m_t = 0; m_idx = 0; m_done = 0; m_zero = 1;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (start) begin m_act = 1; m_t = 0; m_idx = 0; m_zero = 0; end
      end else if (abort) begin
        m_act = 0;
      end else if (m_t == VT) begin
        if (ready) begin
          if (m_idx == NB - 1) begin m_act = 0; m_done = 1; end
          else begin m_idx++; m_t = 0; end
        end
      end else begin
        m_t++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int r;
    if (armed) begin
      chk("clr",   32'(clr),   32'(m_act && m_t == 0));
      chk("loadw", 32'(loadw), 32'(m_act && m_t == 1));
      chk("en",    32'(en),    32'(m_act && m_t >= 2 && m_t < VT));
      chk("valid", 32'(valid), 32'(m_act && m_t == VT));
      chk("busy",  32'(busy),  32'(m_act));
      chk("stage_done", 32'(sdone), 32'(m_done));
      chk("tw_addr",  32'(twaddr), 32'(m_idx));
      chk("bfly_idx", 32'(bidx),   32'(m_idx));
      if (m_act && m_t >= 1) begin
        chk("w_real", 32'(wre), 32'(tbl_re[m_idx]));
        chk("w_img",  32'(wim), 32'(tbl_im[m_idx]));
      end
      if (m_zero) begin
        chk("w_real_rst", 32'(wre), 0);
        chk("cnt_rst", 32'({c_r0, c_i0, c_r1, c_i1}), 0);
      end
      if (m_act && m_t == 1)
        chk("cnt_clear", 32'({c_r0, c_i0, c_r1, c_i1}), 0);
      if (m_act && m_t == VT) begin
        chk("cnt_real0", 32'(c_r0), 32'(ssum(0)));
        chk("cnt_img0",  32'(c_i0), 32'(ssum(1)));
        chk("cnt_real1", 32'(c_r1), 32'(ssum(2)));
        chk("cnt_img1",  32'(c_i1), 32'(ssum(3)));
      end
      if (sdone) ndone++;
    end
    if (m_act && m_t >= 2 && m_t < VT) begin
      r = m_t - 2;
      r0 = sbit(0, r); i0 = sbit(1, r); r1 = sbit(2, r); i1 = sbit(3, r);
    end else begin
      r0 = 1'b1; i0 = 1'b1; r1 = 1'b1; i1 = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // which: 0 = oValid, 1 = oStageDone, 2 = oEn on butterfly 1
  task automatic wait_sig(input int which, input int bound, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < bound) begin
      tick();
      n++;
      case (which)
        0:       hit = valid;
        1:       hit = sdone;
        default: hit = en && (twaddr == 1);
      endcase
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_%0d: no event within %0d cycles", which, bound);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int n;
    rstn = 1'b0; start = 1'b1; abort = 1'b0; ready = 1'b0;
    r0 = 1'b0; i0 = 1'b0; r1 = 1'b0; i1 = 1'b0;
    tick();
    armed = 1;
    tick(); tick();
    rstn = 1'b1; start = 1'b0;
    tick();
    chk("idle_after_rst", 32'(busy), 0);

    // Full stage with continuous ready
    ready = 1'b1;
    pulse_start();
    wait_sig(0, 100, n);
    chk("first_valid_latency", n, 20);
    chk("lit_real0", 32'(c_r0), 16);
    chk("lit_img0",  32'(c_i0), 0);
    chk("lit_real1", 32'(c_r1), 8);
    chk("lit_img1",  32'(c_i1), 1);
    chk("lit_wreal", 32'(wre), 3);
    wait_sig(1, 400, n);
    tick();
    chk("done_count_1", ndone, 1);

    // Backpressure in DONE
    ready = 1'b0;
    pulse_start();
    wait_sig(0, 100, n);
    repeat (10) tick();
    chk("bp_valid_held", 32'(valid), 1);
    ready = 1'b1;
    tick();
    chk("bp_clr_next", 32'(clr), 1);
    chk("bp_addr_next", 32'(twaddr), 1);
    wait_sig(1, 400, n);
    tick();
    chk("done_count_2", ndone, 2);

    // Abort at RUN cycle 5 of butterfly 1, then restart
    pulse_start();
    wait_sig(2, 200, n);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(valid), 0);
    repeat (3) tick();
    chk("abort_no_done", ndone, 2);
    pulse_start();
    chk("restart_clr", 32'(clr), 1);
    chk("restart_addr", 32'(twaddr), 0);
    wait_sig(1, 400, n);
    tick();
    chk("done_count_3", ndone, 3);

    // Reset during DONE, start held during reset, then start+abort together
    ready = 1'b0;
    pulse_start();
    wait_sig(0, 100, n);
    rstn = 1'b0; start = 1'b1;
    tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_cnt", 32'(c_r0), 0);
    chk("rst_wreal", 32'(wre), 0);
    rstn = 1'b1; start = 1'b0;
    tick();
    chk("rst_start_ignored", 32'(busy), 0);
    ready = 1'b1; abort = 1'b1;
    pulse_start();
    chk("start_beats_abort", 32'(clr), 1);
    wait_sig(1, 400, n);
    tick();
    chk("done_count_4", ndone, 4);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
